// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite frame-memory read arbiter.
// Pure declarations: no logic, no latency, no flow control.
package sprite_arb_pkg;

  typedef enum logic {ARB, LOCKED} state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 24;

  // Callers only pass one-hot or zero vectors, so OR-ing set positions yields the index.
  function automatic logic [7:0] onehot_to_idx(input logic [31:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational one-hot picker: first eligible request searching upward from i_ptr+1 (mod N_REQ).
// Zero latency; no flow control, the result is valid in the same cycle as the inputs.
module arb_rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  logic [N_REQ-1:0] w_elig;
  logic             w_found;

  assign w_elig = i_req & ~i_mask;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_elig[(int'(i_ptr) + k) % N_REQ]) begin
        o_gnt[(int'(i_ptr) + k) % N_REQ] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Shares one frame-memory read port among N_REQ renderers; grant is combinational, rvalid returns RD_LAT cycles later.
// No return-path backpressure; requesters hold req until granted. SPRITE_ARB_RR_EN selects round-robin over fixed priority.
module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 32,
  parameter int RD_LAT    = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_lock,
  input  logic [N_REQ*ADDR_W-1:0]  i_addr,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_mem_re,
  output logic [ADDR_W-1:0]        o_mem_addr,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_owner
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  logic [7:0]       r_burst_cnt;
  logic [IDX_W-1:0] r_owner;
  logic             r_yield;
  logic [IDX_W-1:0] r_yield_idx;
  logic [N_REQ-1:0] r_tag [RD_LAT];

  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [N_REQ-1:0] w_pick;
  logic [N_REQ-1:0] w_gnt;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_owner_oh;
  logic [N_REQ-1:0] w_yield_oh;

`ifdef SPRITE_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = IDX_W'(N_REQ - 1);
`endif

  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign w_yield_oh = N_REQ'(1) << r_yield_idx;
  // A burst-limited owner steps aside once, but only if someone else is waiting.
  assign w_mask = (r_yield && |(i_req & ~w_yield_oh)) ? w_yield_oh : '0;

  arb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req  (i_req),
    .i_mask (w_mask),
    .i_ptr  (w_ptr),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_gnt = '0;
    if (!Reset) w_gnt = (r_state == LOCKED) ? (w_owner_oh & i_req) : w_pick;
  end

  assign w_idx = IDX_W'(onehot_to_idx(32'(w_gnt)));

  always_comb begin
    o_mem_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) o_mem_addr = i_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign o_gnt    = w_gnt;
  assign o_mem_re = |w_gnt;
  assign o_rdata  = i_mem_rdata;
  assign o_rvalid = r_tag[RD_LAT-1];
  assign o_busy   = (r_state == LOCKED);
  assign o_owner  = r_owner;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ARB;
      r_burst_cnt <= '0;
      r_owner     <= '0;
      r_yield     <= 1'b0;
      r_yield_idx <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
`ifdef SPRITE_ARB_RR_EN
      r_ptr       <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      r_tag[0] <= w_gnt;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_yield <= 1'b0;
      case (r_state)
        ARB: begin
          if (o_mem_re) begin
`ifdef SPRITE_ARB_RR_EN
            r_ptr <= w_idx;
`endif
            if (i_lock[w_idx]) begin
              r_state     <= LOCKED;
              r_owner     <= w_idx;
              r_burst_cnt <= 8'd1;
            end
          end
        end
        LOCKED: begin
          // Reaching here with lock still high means the burst limit forced the exit.
          if (!i_lock[r_owner] || (o_mem_re && r_burst_cnt == 8'(MAX_BURST - 1))) begin
            r_state     <= ARB;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_yield     <= i_lock[r_owner];
            r_yield_idx <= r_owner;
`ifdef SPRITE_ARB_RR_EN
            r_ptr       <= r_owner;
`endif
          end else if (o_mem_re) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter with a scoreboard of expected read returns.
module tb_sprite_mem_arbiter;

  localparam int N      = 4;
  localparam int AW     = 19;
  localparam int DW     = 24;
  localparam int RD_LAT = 2;
  localparam int MAXB   = 32;
`ifdef SPRITE_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_lock;
  logic [N*AW-1:0] i_addr;
  logic [N-1:0]    o_gnt;
  logic [N-1:0]    o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic            o_mem_re;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   i_mem_rdata;
  logic            o_busy;
  logic [1:0]      o_owner;

  sprite_mem_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .RD_LAT(RD_LAT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_req       (i_req),
    .i_lock      (i_lock),
    .i_addr      (i_addr),
    .o_gnt       (o_gnt),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_mem_re    (o_mem_re),
    .o_mem_addr  (o_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_owner     (o_owner)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  logic [AW-1:0] addr_tab [N] = '{19'h00010, 19'h00200, 19'h00100, 19'h40003};

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {5'd0, a} ^ 24'h5AC396;
  endfunction

  // Memory model: registered read pipeline of depth RD_LAT.
  logic [DW-1:0] mem_pipe [RD_LAT];
  always @(posedge Clk) begin
    mem_pipe[0] <= o_mem_re ? data_of(o_mem_addr) : '0;
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign i_mem_rdata = mem_pipe[RD_LAT-1];

  typedef struct {
    int            due;
    logic [N-1:0]  oh;
    logic [DW-1:0] dat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        total++;
        assert (o_rvalid === mon_e.oh) else begin
          bad++; $error("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, o_rvalid, mon_e.oh);
        end
        total++;
        assert (o_rdata === mon_e.dat) else begin
          bad++; $error("FAIL rdata cyc=%0d got=%h exp=%h", cyc, o_rdata, mon_e.dat);
        end
      end else begin
        total++;
        assert (o_rvalid === '0) else begin
          bad++; $error("FAIL rvalid_idle cyc=%0d got=%b exp=0000", cyc, o_rvalid);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                      input logic [N-1:0] exp_gnt, input logic exp_busy,
                      input logic [1:0] exp_own, input string tag);
    logic [AW-1:0] ea;
    ea = '0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) ea = addr_tab[i];
    Reset  = rst;
    i_req  = req;
    i_lock = lock;
    @(negedge Clk);
    total++;
    assert (o_gnt === exp_gnt) else begin
      bad++; $error("FAIL %s gnt cyc=%0d got=%b exp=%b", tag, cyc, o_gnt, exp_gnt);
    end
    total++;
    assert (o_mem_re === (|exp_gnt)) else begin
      bad++; $error("FAIL %s mem_re got=%b exp=%b", tag, o_mem_re, |exp_gnt);
    end
    total++;
    assert (o_mem_addr === ea) else begin
      bad++; $error("FAIL %s mem_addr got=%h exp=%h", tag, o_mem_addr, ea);
    end
    if (!rst) begin
      total++;
      assert (o_busy === exp_busy) else begin
        bad++; $error("FAIL %s busy got=%b exp=%b", tag, o_busy, exp_busy);
      end
      total++;
      assert (o_owner === exp_own) else begin
        bad++; $error("FAIL %s owner got=%0d exp=%0d", tag, o_owner, exp_own);
      end
    end
    if (exp_gnt != '0) sb.push_back('{cyc + RD_LAT, exp_gnt, data_of(ea)});
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset  = 1'b1;
    i_req  = '0;
    i_lock = '0;
    i_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    @(posedge Clk);
    #1;
    mon_en = 1'b1;

    // Requests during reset must not reach the memory.
    repeat (2) step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, "in_reset");
    repeat (10) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");

    for (int k = 0; k < 8; k++)
      step(1'b0, 4'b1111, 4'b0000, RR_MODE ? 4'(1 << (k % 4)) : 4'b0001, 1'b0, 2'd0, "contend");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "gap");

    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "single");
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");

    // Full-length burst by requester 1, then the yield to requester 0.
    step(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd0, "burst_first");
    for (int k = 2; k <= MAXB; k++)
      step(1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, 2'd1, "burst");
    step(1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0, 2'd0, "yield");
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, "beat33");
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");

    // Early release on beat 5, with one stall while another requester waits.
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd0, "rel1");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, "rel2");
    step(1'b0, 4'b0001, 4'b1000, 4'b0000, 1'b1, 2'd3, "stall");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, "rel3");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, "rel4");
    step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, "rel5");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "released");
    repeat (2) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");

    // Reset one cycle after a locked grant: that read must never return.
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0, "pre_rst");
    sb.delete();
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0, "mid_rst");
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, "post_rst");
    repeat (4) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "drain");

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain left=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
